// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, requester IDs and
// the full byte-enable pattern used for instruction fetches.
package mem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t BUSY_IF = 2'd1;
  localparam arb_state_t BUSY_D  = 2'd2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Wide enough for any DATA_W up to 512; users slice the low DATA_W/8 bits.
  localparam logic [63:0] BE_FULL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the unified memory port.
// slave = arbiter side, master = requesters plus memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              timeout_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, timeout_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, timeout_err
  );

endinterface

// File: rtl/arb_wait_timer.sv
// Busy-cycle counter for the memory arbiter; expired flags the last cycle a
// transaction may still wait, so a stall there is the MAX_WAIT-th without ready.
module arb_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin; default is fixed data-over-fetch priority.
//
// state   | meaning
// IDLE    | no transaction; requests sampled every cycle
// BUSY_IF | fetch command on the memory port, waiting for mem_ready
// BUSY_D  | load/store command on the memory port, waiting for mem_ready
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              first_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              terr_q;

  logic is_busy, win_valid, win_id, expired, done, tmo, accept;

  assign is_busy   = (state_q != IDLE);
  assign win_valid = bus.if_req | bus.d_req;
  assign accept    = (state_q == IDLE) && win_valid;
  assign done      = is_busy && bus.mem_ready;
  assign tmo       = is_busy && !bus.mem_ready && expired;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    win_id = REQ_IF;
    if (bus.if_req && bus.d_req) win_id = (last_q == REQ_IF) ? REQ_D : REQ_IF;
    else if (bus.d_req)          win_id = REQ_D;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      last_q <= REQ_IF;
    else if (accept) last_q <= win_id;
  end
`else
  always_comb begin
    win_id = bus.d_req ? REQ_D : REQ_IF;
  end
`endif

  arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == IDLE),
    .en      (is_busy && !bus.mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:            if (win_valid) state_d = (win_id == REQ_D) ? BUSY_D : BUSY_IF;
      BUSY_IF, BUSY_D: if (done || tmo) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      terr_q      <= 1'b0;
    end else begin
      first_q     <= accept;
      if_rvalid_q <= (state_q == BUSY_IF) && (done || tmo);
      d_rvalid_q  <= (state_q == BUSY_D) && (done || tmo);
      if (accept) begin
        if (win_id == REQ_D) begin
          we_q    <= bus.d_we;
          addr_q  <= bus.d_addr;
          wdata_q <= bus.d_wdata;
          be_q    <= bus.d_be;
        end else begin
          we_q    <= 1'b0;
          addr_q  <= bus.if_addr;
          wdata_q <= '0;
          be_q    <= BE_FULL[BE_W-1:0];
        end
      end
      if (state_q == BUSY_IF) begin
        if (done)     if_rdata_q <= bus.mem_rdata;
        else if (tmo) if_rdata_q <= '0;
      end
      // Stores leave d_rdata untouched so the last load value remains visible.
      if (state_q == BUSY_D) begin
        if (done && !we_q) d_rdata_q <= bus.mem_rdata;
        else if (tmo)      d_rdata_q <= '0;
      end
      if (tmo) terr_q <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_req     = is_busy;
    bus.busy        = is_busy;
    bus.if_gnt      = first_q && (state_q == BUSY_IF);
    bus.d_gnt       = first_q && (state_q == BUSY_D);
    bus.if_rvalid   = if_rvalid_q;
    bus.d_rvalid    = d_rvalid_q;
    bus.if_rdata    = if_rdata_q;
    bus.d_rdata     = d_rdata_q;
    bus.mem_we      = we_q;
    bus.mem_addr    = addr_q;
    bus.mem_wdata   = wdata_q;
    bus.mem_be      = be_q;
    bus.timeout_err = terr_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, timeout, reset and
// address-hold scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_be = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    rst_n = 0;
    tick; tick;
    rst_n = 1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b exp 0", bus.mem_req); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    checks++; if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid}); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %0b exp 0", bus.timeout_err); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr); end
    tick;
  endtask

  task automatic test_addr_change;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; bus.d_be = 4'hF;
    tick;
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL addr_d_gnt got %0b exp 1", bus.d_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL addr_mem_we got %0b exp 0", bus.mem_we); end
    bus.d_req = 0; bus.d_addr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.mem_addr !== 32'h40 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL addr_hold[%0d] got addr %h req %0b exp 40/1", i, bus.mem_addr, bus.mem_req); end
      tick;
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'h12345678;
    checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL addr_hold_last got %h exp 40", bus.mem_addr); end
    tick;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin errors++; $display("FAIL addr_rvalid got %0b/%h exp 1/12345678", bus.d_rvalid, bus.d_rdata); end
    tick;
  endtask

  task automatic test_fetch;
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick;
    checks++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got if %0b d %0b exp 1/0", bus.if_gnt, bus.d_gnt); end
    checks++; if (bus.mem_addr !== 32'h100 || bus.mem_be !== 4'hF || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL fetch_cmd got addr %h be %h we %0b wd %h exp 100/f/0/0", bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata); end
    checks++; if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL fetch_req got %0b/%0b exp 1/1", bus.mem_req, bus.busy); end
    bus.if_req = 0;
    tick;
    checks++; if (bus.if_gnt !== 1'b0 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_gnt_pulse got gnt %0b req %0b exp 0/1", bus.if_gnt, bus.mem_req); end
    tick;
    bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
    checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_early_rvalid got %0b exp 0", bus.if_rvalid); end
    tick;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_rvalid got %0b/%h exp 1/00500093", bus.if_rvalid, bus.if_rdata); end
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL fetch_idle got %0b/%0b exp 0/0", bus.mem_req, bus.busy); end
    tick;
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_rvalid_pulse got %0b/%h exp 0/00500093", bus.if_rvalid, bus.if_rdata); end
  endtask

  task automatic test_priority;
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'h3;
    tick;
    checks++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin errors++; $display("FAIL prio_gnt got d %0b if %0b exp 1/0", bus.d_gnt, bus.if_gnt); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'h3 || bus.mem_addr !== 32'h2000 || bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_cmd got we %0b be %h addr %h wd %h exp 1/3/2000/deadbeef", bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    bus.d_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
    tick;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin errors++; $display("FAIL prio_store_rvalid got %0b/%h exp 1/12345678", bus.d_rvalid, bus.d_rdata); end
    checks++; if (bus.if_gnt !== 1'b0) begin errors++; $display("FAIL prio_no_b2b got %0b exp 0", bus.if_gnt); end
    tick;
    checks++; if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h104 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL prio_if_after got gnt %0b addr %h we %0b exp 1/104/0", bus.if_gnt, bus.mem_addr, bus.mem_we); end
    bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h00000013;
    tick;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h00000013) begin errors++; $display("FAIL prio_if_rvalid got %0b/%h exp 1/00000013", bus.if_rvalid, bus.if_rdata); end
    tick;
  endtask

  task automatic test_zero_be;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h44; bus.d_wdata = 32'h55; bus.d_be = 4'h0;
    tick;
    checks++; if (bus.d_gnt !== 1'b1 || bus.mem_be !== 4'h0 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h55 || bus.mem_addr !== 32'h44) begin errors++; $display("FAIL zero_be_cmd got gnt %0b be %h we %0b wd %h addr %h exp 1/0/1/55/44", bus.d_gnt, bus.mem_be, bus.mem_we, bus.mem_wdata, bus.mem_addr); end
    bus.d_req = 0; bus.mem_ready = 1;
    tick;
    bus.mem_ready = 0;
    checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL zero_be_rvalid got %0b exp 1", bus.d_rvalid); end
    tick;
  endtask

  task automatic test_timeout;
    int cnt;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; bus.d_be = 4'hF;
    tick;
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL tmo_gnt got %0b exp 1", bus.d_gnt); end
    bus.d_req = 0;
    cnt = 0;
    for (int i = 0; i < 40 && bus.mem_req === 1'b1; i++) begin
      cnt++;
      tick;
    end
    checks++; if (cnt != 15) begin errors++; $display("FAIL tmo_req_cycles got %0d exp 15", cnt); end
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rvalid got %0b/%h exp 1/0", bus.d_rvalid, bus.d_rdata); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %0b exp 1", bus.timeout_err); end
    tick;
    bus.if_req = 1; bus.if_addr = 32'h108;
    tick;
    checks++; if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL tmo_next_gnt got %0b exp 1", bus.if_gnt); end
    bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hA5A5A5A5;
    tick;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL tmo_next_rvalid got %0b/%h exp 1/a5a5a5a5", bus.if_rvalid, bus.if_rdata); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0b exp 1", bus.timeout_err); end
    tick;
  endtask

  task automatic test_reset_mid;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500; bus.d_be = 4'hF;
    tick;
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %0b exp 1", bus.d_gnt); end
    bus.d_req = 0;
    tick;
    rst_n = 0;
    tick;
    rst_n = 1;
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got req %0b busy %0b rv %0b exp 0/0/0", bus.mem_req, bus.busy, bus.d_rvalid); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_err_clr got %0b exp 0", bus.timeout_err); end
    bus.mem_ready = 1; bus.mem_rdata = 32'hFFFF0000;
    tick;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    checks++; if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_ready_ignored got %0b/%0b/%0b exp 0/0/0", bus.d_rvalid, bus.if_rvalid, bus.busy); end
    bus.if_req = 1; bus.if_addr = 32'h600;
    tick;
    checks++; if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h600) begin errors++; $display("FAIL rstmid_fresh got gnt %0b addr %h exp 1/600", bus.if_gnt, bus.mem_addr); end
    bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h11112222;
    tick;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h11112222) begin errors++; $display("FAIL rstmid_fresh_rvalid got %0b/%h exp 1/11112222", bus.if_rvalid, bus.if_rdata); end
    tick;
  endtask

`ifdef MEM_ARB_RR_EN
  task automatic test_round_robin;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h700; bus.d_be = 4'hF;
    tick;
    bus.d_req = 0; bus.mem_ready = 1;
    tick;
    bus.mem_ready = 0;
    tick;
    bus.if_req = 1; bus.if_addr = 32'h800; bus.d_req = 1; bus.d_addr = 32'h900;
    tick;
    checks++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin errors++; $display("FAIL rr_if_first got if %0b d %0b exp 1/0", bus.if_gnt, bus.d_gnt); end
    bus.if_req = 0; bus.mem_ready = 1;
    tick;
    bus.mem_ready = 0;
    tick;
    checks++; if (bus.d_gnt !== 1'b1 || bus.mem_addr !== 32'h900) begin errors++; $display("FAIL rr_d_second got gnt %0b addr %h exp 1/900", bus.d_gnt, bus.mem_addr); end
    bus.d_req = 0; bus.mem_ready = 1;
    tick;
    bus.mem_ready = 0;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_addr_change;
    test_fetch;
    test_priority;
    test_zero_be;
    test_timeout;
    test_reset_mid;
`ifdef MEM_ARB_RR_EN
    test_round_robin;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
